codificador_display: RTL and testbench
======================================

CODIFICADOR_DISPLAY -- requirements
Module: codificador_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of buffered/displayed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clocks each digit stays selected (legal >=1).
REQ-003 SHALL have port Clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Input  input  4  nibble to encode.
REQ-006 SHALL have port Ready  input  1  load request; rising edge loads one nibble.
REQ-007 SHALL have port Clear  input  1  synchronous buffer flush, active-high.
REQ-008 SHALL have port Output  output  4  registered code of the most recently loaded nibble.
REQ-009 SHALL have port Count  output  $clog2(DIGITS+1)  number of valid digits.
REQ-010 SHALL have port Full  output  1  high when Count==DIGITS.
REQ-011 SHALL have port DigitSel  output  DIGITS  one-hot digit enable, active-high.
REQ-012 SHALL have port Segments  output  7  {a,b,c,d,e,f,g}, active-high (1 = lit).

Function
REQ-013 SHALL map codes as 0->E 1->A 2->4 3->D 4->6 5->1 6->7 7->F 8->0 9->B A->2 B->8 C->9 D->3 E->C F->5.
REQ-014 SHALL register Ready each cycle; a load occurs on the edge where Ready=1 and the registered Ready=0; level-held Ready loads once.
REQ-015 On load, SHALL shift the buffer up one position, write the code of Input into digit 0, and update Output, all on that same edge.
REQ-016 On load with Count<DIGITS, SHALL increment Count; with Full=1, SHALL drop digit DIGITS-1 and hold Count.
REQ-017 Clear SHALL zero the buffer, Count and Output next edge; Clear and load in the same cycle: Clear wins, and the load is discarded.
REQ-018 Scan counter SHALL hold each digit index SCAN_DIV clocks, cycle 0,1,..,DIGITS-1,0 with wrap, and be unaffected by load/Clear.
REQ-019 DigitSel/Segments SHALL be registered, reflecting the scan index and buffer contents from the previous cycle (1-cycle latency).
REQ-020 Segments SHALL show standard hex font (b, d lowercase) for digit positions < Count, and 7'b0 for positions >= Count.
REQ-021 DIGITS=1 SHALL keep DigitSel=1 permanently.

Reset
REQ-022 Reset SHALL clear buffer, Output=0, Count=0, Full=0, scan index 0, the scan divider, and the registered Ready=0, next edge.
REQ-023 After Reset, DigitSel SHALL be 1 (digit 0) and Segments 0; Reset mid-scan or mid-load SHALL override everything, including Clear and load.
REQ-024 Ready held high through Reset release SHALL NOT cause a load until it falls and rises again.

Configuration
REQ-025 Macro CODIFICADOR_DECODE_EN, when defined, SHALL add port Mode  input  1; Mode=1 applies the inverse table (e.g. E->0), Mode=0 the forward table, and Mode is sampled on the load edge.
REQ-026 Without CODIFICADOR_DECODE_EN, the Mode port SHALL be absent and only the forward table SHALL be used.

Structure
REQ-027 Package codificador_pkg SHALL hold the forward code table, the inverse code table, the 16-entry hex segment font, and the DIGITS maximum constant.
REQ-028 Sub-module seg_font SHALL be the sole natural sub-module (combinational nibble->segments lookup using the package font).

Verification (DIGITS=4, SCAN_DIV=4)
REQ-029 Reset asserted 2 cycles -> Output=0, Count=0, Full=0, DigitSel=0001, Segments=0.
REQ-030 Load Input 0,3,8,F -> digits[3:0]=E,D,0,5; Output=5; Count=4; Full=1.
REQ-031 Fifth load Input 5 -> digits[3:0]=D,0,5,1; Output=1; Count=4.
REQ-032 Ready held high 10 cycles with Input 8 -> exactly one load; Count=1.
REQ-033 Clear with a Ready rising edge in the same cycle -> Count=0; Segments=0 on all digits.
REQ-034 One load of Input 8 -> DigitSel 0001,0010,0100,1000, each 4 cycles, repeating; Segments=7'h7E on digit 0, 0 on the others; with CODIFICADOR_DECODE_EN, Mode=1 and Input E -> Output 0.

Source files
------------

// File: rtl/codificador_pkg.sv
// Shared tables for the display encoder: nibble code maps, hex segment font and digit limit.
package codificador_pkg;

    localparam int DIGITS_MAX = 8;

    // Forward scramble: index is the raw nibble, entry is the stored code.
    localparam logic [3:0] FWD_CODE [16] = '{
        4'hE, 4'hA, 4'h4, 4'hD, 4'h6, 4'h1, 4'h7, 4'hF,
        4'h0, 4'hB, 4'h2, 4'h8, 4'h9, 4'h3, 4'hC, 4'h5
    };

    localparam logic [3:0] INV_CODE [16] = '{
        4'h8, 4'h5, 4'hA, 4'hD, 4'h2, 4'hF, 4'h4, 4'h6,
        4'hB, 4'hC, 4'h1, 4'h9, 4'hE, 4'h3, 4'h0, 4'h7
    };

    // {a,b,c,d,e,f,g}, 1 = lit; b and d drawn lowercase.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/seg_font.sv
// Combinational nibble to seven-segment lookup.
module seg_font
    import codificador_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/codificador_display.sv
// Nibble encoder with a shifting digit buffer and a multiplexed seven-segment scan.
// Optional macro CODIFICADOR_DECODE_EN adds a Mode input selecting the inverse table.
module codificador_display
    import codificador_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [3:0]                   Input,
    input  logic                         Ready,
    input  logic                         Clear,
`ifdef CODIFICADOR_DECODE_EN
    input  logic                         Mode,
`endif
    output logic [3:0]                   Output,
    output logic [$clog2(DIGITS+1)-1:0]  Count,
    output logic                         Full,
    output logic [DIGITS-1:0]            DigitSel,
    output logic [6:0]                   Segments
);

    localparam int CW   = $clog2(DIGITS + 1);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW   = $clog2(SCAN_DIV + 1);

    logic [DIGITS-1:0][3:0] digits_q, digits_d;
    logic [DIGITS-1:0][6:0] seg_w;
    logic [3:0]             out_q, out_d, code;
    logic [CW-1:0]          count_q, count_d;
    logic                   ready_q, armed_q, load;
    logic [DW-1:0]          div_q, div_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [DIGITS-1:0]      sel_q, sel_d;
    logic [6:0]             seg_q, seg_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_font
        seg_font u_font (.nibble_i(digits_q[g]), .seg_o(seg_w[g]));
    end

`ifdef CODIFICADOR_DECODE_EN
    assign code = Mode ? INV_CODE[Input] : FWD_CODE[Input];
`else
    assign code = FWD_CODE[Input];
`endif

    // armed_q blocks a load until Ready has been seen low, so a Ready held
    // through reset release is not mistaken for a fresh rising edge.
    assign load = Ready & ~ready_q & armed_q;

    always_comb begin
        digits_d = digits_q;
        out_d    = out_q;
        count_d  = count_q;
        if (Clear) begin
            digits_d = '0;
            out_d    = '0;
            count_d  = '0;
        end else if (load) begin
            for (int i = DIGITS - 1; i > 0; i--) digits_d[i] = digits_q[i-1];
            digits_d[0] = code;
            out_d       = code;
            if (count_q != CW'(DIGITS)) count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        sel_d = DIGITS'(1) << idx_q;
        seg_d = (CW'(idx_q) < count_q) ? seg_w[idx_q] : '0;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            digits_q <= '0;
            out_q    <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            armed_q  <= ~Ready;
            div_q    <= '0;
            idx_q    <= '0;
            sel_q    <= DIGITS'(1);
            seg_q    <= '0;
        end else begin
            digits_q <= digits_d;
            out_q    <= out_d;
            count_q  <= count_d;
            ready_q  <= Ready;
            armed_q  <= armed_q | ~Ready;
            div_q    <= div_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
        end
    end

    assign Output   = out_q;
    assign Count    = count_q;
    assign Full     = (count_q == CW'(DIGITS));
    assign DigitSel = sel_q;
    assign Segments = seg_q;

endmodule

// File: tb/tb_codificador_display.sv
// Scoreboard bench for codificador_display with DIGITS=4, SCAN_DIV=4.
module tb_codificador_display;

    logic       Clock = 1'b0;
    logic       Reset, Ready, Clear, Mode;
    logic [3:0] Input, Output, DigitSel;
    logic [2:0] Count;
    logic       Full;
    logic [6:0] Segments;

    always #5 Clock = ~Clock;

    codificador_display #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .Clock(Clock), .Reset(Reset), .Input(Input), .Ready(Ready), .Clear(Clear),
`ifdef CODIFICADOR_DECODE_EN
        .Mode(Mode),
`endif
        .Output(Output), .Count(Count), .Full(Full),
        .DigitSel(DigitSel), .Segments(Segments)
    );

    // kind 0: Output/Count/Full now; 1: DigitSel/Segments now;
    // 2: Segments once DigitSel reaches sel
    typedef struct {
        string      name;
        int         kind;
        logic [3:0] out;
        logic [2:0] cnt;
        logic       full;
        logic [3:0] sel;
        logic [6:0] seg;
    } exp_t;

    exp_t q[$];
    int   applied = 0;
    int   miscompares = 0;
    bit   busy = 1'b0;

    task automatic push_state(input string n, input logic [3:0] o, input logic [2:0] c, input logic f);
        exp_t e;
        e.name = n; e.kind = 0; e.out = o; e.cnt = c; e.full = f; e.sel = '0; e.seg = '0;
        q.push_back(e);
    endtask

    task automatic push_scan(input string n, input int k, input logic [3:0] s, input logic [6:0] g);
        exp_t e;
        e.name = n; e.kind = k; e.out = '0; e.cnt = '0; e.full = 1'b0; e.sel = s; e.seg = g;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        int   n;
        forever begin
            @(negedge Clock);
            while (q.size() > 0) begin
                e = q.pop_front();
                busy = 1'b1;
                applied++;
                case (e.kind)
                    0: if (Output !== e.out || Count !== e.cnt || Full !== e.full) begin
                        miscompares++;
                        $display("FAIL %s: got Output=%h Count=%0d Full=%b, want Output=%h Count=%0d Full=%b",
                                 e.name, Output, Count, Full, e.out, e.cnt, e.full);
                    end
                    1: if (DigitSel !== e.sel || Segments !== e.seg) begin
                        miscompares++;
                        $display("FAIL %s: got DigitSel=%b Segments=%h, want DigitSel=%b Segments=%h",
                                 e.name, DigitSel, Segments, e.sel, e.seg);
                    end
                    default: begin
                        n = 0;
                        while (DigitSel !== e.sel && n < 20) begin
                            @(negedge Clock);
                            n++;
                        end
                        if (DigitSel !== e.sel) begin
                            miscompares++;
                            $display("FAIL %s: DigitSel stuck at %b, want %b", e.name, DigitSel, e.sel);
                        end else if (Segments !== e.seg) begin
                            miscompares++;
                            $display("FAIL %s: got Segments=%h, want %h", e.name, Segments, e.seg);
                        end
                    end
                endcase
                busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drain(input string n);
        int c = 0;
        do begin
            @(negedge Clock);
            #1;
            c++;
        end while ((q.size() != 0 || busy) && c < 200);
        if (c >= 200) begin
            applied++;
            miscompares++;
            $display("FAIL %s: scoreboard did not drain, got %0d pending, want 0", n, q.size());
        end
    endtask

    task automatic load(input logic [3:0] nib);
        tick();
        Input = nib;
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
    endtask

    task automatic wait_sel(input logic [3:0] s);
        int c = 0;
        do begin
            @(negedge Clock);
            c++;
        end while (DigitSel !== s && c < 40);
        if (DigitSel !== s) begin
            applied++;
            miscompares++;
            $display("FAIL scan_sync: got DigitSel=%b, want %b", DigitSel, s);
        end
    endtask

    initial begin
        Reset = 1'b1; Ready = 1'b0; Clear = 1'b0; Input = '0; Mode = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;
        push_state("reset", 4'h0, 3'd0, 1'b0);
        push_scan("reset_scan", 1, 4'b0001, 7'h00);
        drain("reset");

        load(4'h0); push_state("load0", 4'hE, 3'd1, 1'b0); drain("load0");
        load(4'h3); push_state("load3", 4'hD, 3'd2, 1'b0); drain("load3");
        load(4'h8); push_state("load8", 4'h0, 3'd3, 1'b0); drain("load8");
        load(4'hF); push_state("loadF", 4'h5, 3'd4, 1'b1); drain("loadF");
        push_scan("fill_d0", 2, 4'b0001, 7'h5B);
        push_scan("fill_d1", 2, 4'b0010, 7'h7E);
        push_scan("fill_d2", 2, 4'b0100, 7'h3D);
        push_scan("fill_d3", 2, 4'b1000, 7'h4F);
        drain("fill");

        load(4'h5); push_state("load_full", 4'h1, 3'd4, 1'b1); drain("load_full");
        push_scan("drop_d0", 2, 4'b0001, 7'h30);
        push_scan("drop_d1", 2, 4'b0010, 7'h5B);
        push_scan("drop_d2", 2, 4'b0100, 7'h7E);
        push_scan("drop_d3", 2, 4'b1000, 7'h3D);
        drain("drop");

        tick(); Clear = 1'b1; tick(); Clear = 1'b0;
        push_state("clear", 4'h0, 3'd0, 1'b0); drain("clear");

        tick(); Input = 4'h8; Ready = 1'b1;
        repeat (10) tick();
        Ready = 1'b0;
        push_state("level_ready", 4'h0, 3'd1, 1'b0);
        push_scan("level_d0", 2, 4'b0001, 7'h7E);
        push_scan("level_d1", 2, 4'b0010, 7'h00);
        drain("level");

        tick(); Clear = 1'b1; Ready = 1'b1; Input = 4'h3;
        tick(); Clear = 1'b0; Ready = 1'b0;
        push_state("clear_wins", 4'h0, 3'd0, 1'b0);
        push_scan("cw_d0", 2, 4'b0001, 7'h00);
        push_scan("cw_d1", 2, 4'b0010, 7'h00);
        push_scan("cw_d2", 2, 4'b0100, 7'h00);
        push_scan("cw_d3", 2, 4'b1000, 7'h00);
        drain("clear_wins");

        load(4'h8); push_state("scan_load", 4'h0, 3'd1, 1'b0); drain("scan_load");
        wait_sel(4'b1000);
        wait_sel(4'b0001);
        for (int k = 1; k <= 32; k++) begin
            #1;
            push_scan("scan_seq", 1, 4'b0001 << ((k / 4) % 4), ((k / 4) % 4 == 0) ? 7'h7E : 7'h00);
            @(negedge Clock);
        end
        drain("scan_seq");

        tick(); Ready = 1'b1; Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        repeat (3) tick();
        push_state("ready_thru_reset", 4'h0, 3'd0, 1'b0); drain("ready_thru_reset");
        Ready = 1'b0;
        tick();
        load(4'h3); push_state("rearm_load", 4'hD, 3'd1, 1'b0); drain("rearm_load");

`ifdef CODIFICADOR_DECODE_EN
        Mode = 1'b1;
        load(4'hE); push_state("decode_E", 4'h0, 3'd2, 1'b0); drain("decode_E");
        Mode = 1'b0;
        load(4'hE); push_state("encode_E", 4'hC, 3'd3, 1'b0); drain("encode_E");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
